// File: rtl/xbar_pkg.sv
// Shared types and width helpers for the crossbar scheduler.
package xbar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } xbar_state_e;

  // Index width for n items. It never returns 0, so n = 1 still yields a usable field.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_sched_rr_arb.sv
// Round-robin arbiter: the first requester after ptr_i (wrapping) wins.
module rr_arb
  import xbar_pkg::*;
#(
  parameter int unsigned N = 5,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/xbar_sched.sv
// Per-output round-robin lock scheduler driving the crossbar select bus.
// XBAR_SCHED_TIMEOUT_EN adds a forced release of idle locks and the o_timeout port.
module xbar_sched
  import xbar_pkg::*;
#(
  parameter int unsigned N_IN    = 5,
  parameter int unsigned N_OUT   = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_cg,
  input  logic [N_IN-1:0]                i_req,
  input  logic [N_IN*idx_w(N_OUT)-1:0]   i_dest,
  input  logic [N_IN-1:0]                i_last,
  output logic [N_IN-1:0]                o_gnt,
  output logic [N_OUT*idx_w(N_IN)-1:0]   o_select,
  output logic [N_OUT-1:0]               o_selValid
`ifdef XBAR_SCHED_TIMEOUT_EN
  ,
  output logic [N_OUT-1:0]               o_timeout
`endif
);

  localparam int unsigned SW = idx_w(N_IN);
  localparam int unsigned DW = idx_w(N_OUT);

  logic [N_OUT-1:0][N_IN-1:0] gnt_mat;

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    logic [N_IN-1:0] cand;
    logic [N_IN-1:0] arb_gnt;
    logic [SW-1:0]   arb_idx;
    xbar_state_e     state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic            own_req, own_last, xfer, to_hit;
    logic [N_IN-1:0] gnt_loc;
    logic            vld_loc;

    // Out-of-range destinations never match any output index.
    always_comb begin
      cand = '0;
      for (int unsigned r = 0; r < N_IN; r++) begin
        cand[r] = i_req[r] && (i_dest[r*DW +: DW] == DW'(o));
      end
    end

    rr_arb #(.N(N_IN)) u_arb (
      .req_i (cand),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
    );

    assign own_req  = i_req[sel_q];
    assign own_last = i_last[sel_q];
    assign xfer     = (state_q == LOCKED) && i_cg && own_req;

`ifdef XBAR_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign to_hit = (state_q == LOCKED) && i_cg && !own_req &&
                    (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
      cnt_d = cnt_q;
      if (i_cg) begin
        if ((state_q == IDLE) || xfer || to_hit) cnt_d = '0;
        else                                     cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign o_timeout[o] = to_hit;
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q <= IDLE;
        sel_q   <= '0;
        ptr_q   <= SW'(N_IN - 1);
      end else begin
        state_q <= state_d;
        sel_q   <= sel_d;
        ptr_q   <= ptr_d;
      end
    end

    always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      if (i_cg) begin
        unique case (state_q)
          IDLE: begin
            if (|arb_gnt) begin
              state_d = LOCKED;
              sel_d   = arb_idx;
              ptr_d   = arb_idx;
            end
          end
          LOCKED: begin
            if ((xfer && own_last) || to_hit) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_comb begin
      gnt_loc = '0;
      vld_loc = (state_q == LOCKED);
      if (vld_loc && i_cg) gnt_loc[sel_q] = 1'b1;
    end

    assign gnt_mat[o]              = gnt_loc;
    assign o_selValid[o]           = vld_loc;
    assign o_select[o*SW +: SW]    = sel_q;
  end

  // A requester targets a single output, so OR-ing the per-output grants keeps o_gnt one-hot per bit.
  always_comb begin
    o_gnt = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      o_gnt = o_gnt | gnt_mat[o];
    end
  end

endmodule

// File: tb/tb_xbar_sched.sv
// Self-checking bench for xbar_sched: directed scenarios plus random packets against a reference model.
module tb_xbar_sched;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int TO = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cg = 1'b0;
  logic [3:0] i_req = '0;
  logic [7:0] i_dest = '0;
  logic [3:0] i_last = '0;
  logic [3:0] o_gnt;
  logic [7:0] o_select;
  logic [3:0] o_selValid;
`ifdef XBAR_SCHED_TIMEOUT_EN
  logic [3:0] o_timeout;
`endif

  xbar_sched #(.N_IN(NI), .N_OUT(NO), .TIMEOUT(TO)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_cg       (i_cg),
    .i_req      (i_req),
    .i_dest     (i_dest),
    .i_last     (i_last),
    .o_gnt      (o_gnt),
    .o_select   (o_select),
    .o_selValid (o_selValid)
`ifdef XBAR_SCHED_TIMEOUT_EN
    ,
    .o_timeout  (o_timeout)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which requester each output owns, whether it is locked, and its rotation point.
  int m_lock [NO];
  int m_own  [NO];
  int m_ptr  [NO];
  int m_idle [NO];

  task automatic m_reset();
    for (int o = 0; o < NO; o++) begin
      m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = NI - 1; m_idle[o] = 0;
    end
  endtask

  function automatic logic [3:0] exp_gnt(input logic cg);
    logic [3:0] g = '0;
    for (int o = 0; o < NO; o++) if (m_lock[o] != 0 && cg) g[m_own[o]] = 1'b1;
    return g;
  endfunction

  function automatic logic [7:0] exp_sel();
    logic [7:0] s = '0;
    for (int o = 0; o < NO; o++) s[o*2 +: 2] = 2'(m_own[o]);
    return s;
  endfunction

  function automatic logic [3:0] exp_vld();
    logic [3:0] v = '0;
    for (int o = 0; o < NO; o++) v[o] = (m_lock[o] != 0);
    return v;
  endfunction

  task automatic m_advance(input logic [3:0] req, input logic [7:0] dest,
                           input logic [3:0] last, input logic cg, output logic [3:0] eto);
    eto = '0;
    if (!cg) return;
    for (int o = 0; o < NO; o++) begin
      if (m_lock[o] == 0) begin
        for (int k = 1; k <= NI; k++) begin
          int r;
          r = (m_ptr[o] + k) % NI;
          if (req[r] && int'(dest[r*2 +: 2]) == o) begin
            m_lock[o] = 1; m_own[o] = r; m_ptr[o] = r; m_idle[o] = 0;
            break;
          end
        end
      end else begin
        int r;
        r = m_own[o];
        if (req[r]) begin
          m_idle[o] = 0;
          if (last[r]) m_lock[o] = 0;
        end else begin
          m_idle[o]++;
`ifdef XBAR_SCHED_TIMEOUT_EN
          if (m_idle[o] == TO) begin
            m_lock[o] = 0; m_idle[o] = 0; eto[o] = 1'b1;
          end
`endif
        end
      end
    end
  endtask

  function automatic logic [7:0] D(input int d0, input int d1, input int d2, input int d3);
    return {2'(d3), 2'(d2), 2'(d1), 2'(d0)};
  endfunction

  // One cycle: drive at the falling edge, check the model, then cross the rising edge.
  task automatic step(input logic [3:0] req, input logic [7:0] dest,
                      input logic [3:0] last, input logic cg);
    logic [3:0] eto;
    i_req = req; i_dest = dest; i_last = last; i_cg = cg;
    #1;
    check("gnt", 32'(o_gnt), 32'(exp_gnt(cg)));
    check("select", 32'(o_select), 32'(exp_sel()));
    check("selValid", 32'(o_selValid), 32'(exp_vld()));
    m_advance(req, dest, last, cg, eto);
`ifdef XBAR_SCHED_TIMEOUT_EN
    check("timeout", 32'(o_timeout), 32'(eto));
`endif
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  logic [3:0] rq, ls, g;
  logic [7:0] ds;
  logic       cgr;
  int         act [NI];
  int         dst [NI];

  initial begin
    m_reset();
    repeat (2) @(negedge i_clk);
    check("rst_gnt", 32'(o_gnt), 32'h0);
    check("rst_select", 32'(o_select), 32'h0);
    check("rst_selValid", 32'(o_selValid), 32'h0);
    i_rst_n = 1'b1;
    i_cg    = 1'b1;

    // Fair rotation on output 1 between requesters 0 and 2.
    step(4'b0101, D(1,0,1,0), 4'b0101, 1'b1);
    check("t1_gnt_r0", 32'(o_gnt), 32'b0001);
    check("t1_sel_r0", 32'(o_select[3:2]), 32'd0);
    step(4'b0101, D(1,0,1,0), 4'b0101, 1'b1);
    check("t1_bubble_vld", 32'(o_selValid[1]), 32'd0);
    check("t1_bubble_sel", 32'(o_select[3:2]), 32'd0);
    step(4'b0100, D(1,0,1,0), 4'b0100, 1'b1);
    check("t1_gnt_r2", 32'(o_gnt), 32'b0100);
    check("t1_sel_r2", 32'(o_select[3:2]), 32'd2);
    step(4'b0101, D(1,0,1,0), 4'b0101, 1'b1);
    step(4'b0001, D(1,0,1,0), 4'b0001, 1'b1);
    check("t1_gnt_r0_again", 32'(o_gnt), 32'b0001);
    step(4'b0001, D(1,0,1,0), 4'b0001, 1'b1);
    step(4'b0000, D(1,0,1,0), 4'b0000, 1'b1);

    // Three-beat packet from requester 3 with a pause, requester 1 waiting on the same output.
    step(4'b1000, D(0,0,0,0), 4'b0000, 1'b1);
    check("t2_lock_r3", 32'(o_gnt), 32'b1000);
    step(4'b1010, D(0,0,0,0), 4'b0000, 1'b1);
    step(4'b0010, D(0,0,0,0), 4'b0000, 1'b1);
    check("t2_pause_gnt", 32'(o_gnt), 32'b1000);
    step(4'b0010, D(0,0,0,0), 4'b0000, 1'b1);
    step(4'b1010, D(0,0,0,0), 4'b0000, 1'b1);
    step(4'b1010, D(0,0,0,0), 4'b1000, 1'b1);
    check("t2_after_last", 32'(o_gnt), 32'b0000);
    step(4'b0010, D(0,0,0,0), 4'b0000, 1'b1);
    check("t2_gnt_r1", 32'(o_gnt), 32'b0010);
    step(4'b0010, D(0,0,0,0), 4'b0010, 1'b1);
    step(4'b0000, D(0,0,0,0), 4'b0000, 1'b1);

    // All four outputs locked in parallel, then clock gating while locked.
    step(4'b1111, D(3,2,1,0), 4'b0000, 1'b1);
    check("t3_gnt", 32'(o_gnt), 32'b1111);
    check("t3_select", 32'(o_select), 32'h1B);
    check("t3_selValid", 32'(o_selValid), 32'b1111);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, D(3,2,1,0), 4'b1111, 1'b0);
      check("t4_cg_gnt", 32'(o_gnt), 32'b0000);
      check("t4_cg_select", 32'(o_select), 32'h1B);
      check("t4_cg_vld", 32'(o_selValid), 32'b1111);
    end
    step(4'b1111, D(3,2,1,0), 4'b1111, 1'b1);
    check("t4_release", 32'(o_selValid), 32'b0000);
    step(4'b0000, D(3,2,1,0), 4'b0000, 1'b1);

    // Asynchronous reset in the middle of a packet.
    step(4'b0100, D(0,0,1,0), 4'b0000, 1'b1);
    step(4'b0100, D(0,0,1,0), 4'b0000, 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(o_gnt), 32'h0);
    check("t5_rst_vld", 32'(o_selValid), 32'h0);
    check("t5_rst_sel", 32'(o_select), 32'h0);
    m_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(4'b0110, D(0,2,2,0), 4'b0000, 1'b1);
    check("t5_first_gnt", 32'(o_gnt), 32'b0010);
    check("t5_first_sel", 32'(o_select[5:4]), 32'd1);
    step(4'b0110, D(0,2,2,0), 4'b0010, 1'b1);
    step(4'b0100, D(0,2,2,0), 4'b0100, 1'b1);
    step(4'b0100, D(0,2,2,0), 4'b0100, 1'b1);
    step(4'b0000, D(0,2,2,0), 4'b0000, 1'b1);

`ifdef XBAR_SCHED_TIMEOUT_EN
    step(4'b0100, D(0,0,3,0), 4'b0000, 1'b1);
    for (int i = 0; i < TO; i++) step(4'b0000, D(0,0,3,0), 4'b0000, 1'b1);
    check("t6_vld_after_timeout", 32'(o_selValid[3]), 32'd0);
`endif

    // Random packets obeying the hold-dest-until-last rule.
    for (int r = 0; r < NI; r++) begin act[r] = 0; dst[r] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      ds = '0;
      for (int r = 0; r < NI; r++) begin
        if (act[r] == 0 && $urandom_range(0, 2) == 0) begin
          act[r] = 1; dst[r] = int'($urandom_range(0, NO - 1));
        end
        rq[r] = (act[r] != 0) && ($urandom_range(0, 3) != 0);
        ls[r] = ($urandom_range(0, 2) == 0);
        ds[r*2 +: 2] = 2'(dst[r]);
      end
      cgr = ($urandom_range(0, 9) != 0);
      g   = exp_gnt(cgr);
      step(rq, ds, ls, cgr);
      for (int r = 0; r < NI; r++) if (rq[r] && g[r] && ls[r]) act[r] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
